regbank_arbiter: RTL and testbench

- Sequences and shares the 32x32 register bank between two requesters: core (id 0) and debug/loader port (id 1).
- The bank has no clock and reacts to edges on its write_reg/read_reg strobes. This block gives it stable addresses and data, emits clean one-cycle strobes, and captures read data.
- It returns a tagged response to the requester that issued the operation.
- Sits between the core datapath/debug unit and the register bank instance.

---
 rtl/regbank_arbiter.sv | 77 +++++++
 tb/tb_regbank_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: shares the clockless 32x32 register bank between core (id 0) and debug (id 1) with clean one-cycle strobes
module regbank_arbiter #(
   parameter bit CORE_PRIORITY    = 1'b1,
   parameter bit ZERO_REG_PROTECT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_write,
   input  logic [9:0]  req_rs,
   input  logic [9:0]  req_rt,
   input  logic [9:0]  req_rd,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_data_1,
   output logic [31:0] rsp_data_2,
   output logic [4:0]  bank_rs,
   output logic [4:0]  bank_rt,
   output logic [4:0]  bank_rd,
   output logic        bank_write_reg,
   output logic        bank_read_reg,
   output logic [31:0] bank_write_data,
   input  logic [31:0] bank_data_1,
   input  logic [31:0] bank_data_2
);
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, CAPTURE} state_t;
   state_t state, state_nx;
   logic last_grant, op_id, op_write, sel;
   logic [1:0] grant;
   always_comb begin
      grant     = (&req_valid) ? ((CORE_PRIORITY || last_grant) ? 2'b01 : 2'b10) : req_valid;
      req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
      sel       = req_ready[1];
      state_nx  = state == IDLE   ? ((|req_ready) ? SETUP : IDLE) :
                  state == SETUP  ? STROBE :
                  state == STROBE ? CAPTURE : IDLE;
   end
   always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
   // Strobes are launched from SETUP so they rise a full cycle after the addresses settle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant      <= 1'b1;
         op_id           <= 1'b0;
         op_write        <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_id          <= 1'b0;
         rsp_data_1      <= '0;
         rsp_data_2      <= '0;
         bank_rs         <= '0;
         bank_rt         <= '0;
         bank_rd         <= '0;
         bank_write_reg  <= 1'b0;
         bank_read_reg   <= 1'b0;
         bank_write_data <= '0;
      end else begin
         rsp_valid      <= state == CAPTURE;
         bank_write_reg <= state == SETUP && op_write && !(ZERO_REG_PROTECT && bank_rd == 5'd0);
         bank_read_reg  <= state == SETUP && !op_write;
         if (state == CAPTURE) rsp_id <= op_id;
         if (state == CAPTURE && !op_write) begin
            rsp_data_1 <= bank_data_1;
            rsp_data_2 <= bank_data_2;
         end
         if (|req_ready) begin
            op_id           <= sel;
            op_write        <= req_write[sel];
            last_grant      <= sel;
            bank_rs         <= sel ? req_rs[9:5] : req_rs[4:0];
            bank_rt         <= sel ? req_rt[9:5] : req_rt[4:0];
            bank_rd         <= sel ? req_rd[9:5] : req_rd[4:0];
            bank_write_data <= sel ? req_wdata[63:32] : req_wdata[31:0];
         end
      end
   end
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: directed and random checks of the bank arbiter against an operation-level reference model
module tb_regbank_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  valid = '0, write = '0, req_ready;
   logic [9:0]  rs = '0, rt = '0, rd = '0;
   logic [63:0] wdata = '0;
   logic        rsp_valid, rsp_id, bank_write_reg, bank_read_reg;
   logic [31:0] rsp_data_1, rsp_data_2, bank_write_data;
   logic [4:0]  bank_rs, bank_rt, bank_rd;
   logic [31:0] bd1 = '0, bd2 = '0;
   logic [31:0] bregs [32] = '{default: '0};
   logic [1:0]  p_valid = '0, p_ready;
   logic        p_rsp_valid, p_rsp_id, p_wr, p_rd_s;
   logic [31:0] p_d1, p_d2, p_wd;
   logic [4:0]  p_rs, p_rt, p_rdd;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int age = -1;
   bit last_g = 1'b1;
   logic [1:0] hs = '0;
   logic o_id = 0, o_w = 0;
   logic [4:0] o_rs = 0, o_rt = 0, o_rd = 0;
   logic [31:0] o_wd = 0, r_d1 = 0, r_d2 = 0, e_d1 = 0, e_d2 = 0;
   logic [31:0] mregs [32] = '{default: '0};
   int h1, h2, h3;

   always #5 clk = ~clk;

   regbank_arbiter #(.CORE_PRIORITY(1'b0), .ZERO_REG_PROTECT(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_ready(req_ready), .req_write(write),
      .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data_1(rsp_data_1), .rsp_data_2(rsp_data_2),
      .bank_rs(bank_rs), .bank_rt(bank_rt), .bank_rd(bank_rd), .bank_write_reg(bank_write_reg),
      .bank_read_reg(bank_read_reg), .bank_write_data(bank_write_data),
      .bank_data_1(bd1), .bank_data_2(bd2));

   regbank_arbiter #(.CORE_PRIORITY(1'b1), .ZERO_REG_PROTECT(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(p_valid), .req_ready(p_ready), .req_write(2'b00),
      .req_rs(10'd0), .req_rt(10'd0), .req_rd(10'd0), .req_wdata(64'd0),
      .rsp_valid(p_rsp_valid), .rsp_id(p_rsp_id), .rsp_data_1(p_d1), .rsp_data_2(p_d2),
      .bank_rs(p_rs), .bank_rt(p_rt), .bank_rd(p_rdd), .bank_write_reg(p_wr),
      .bank_read_reg(p_rd_s), .bank_write_data(p_wd),
      .bank_data_1(32'h0), .bank_data_2(32'h0));

   // Edge-triggered bank: acts only on rising strobes, like the real clockless bank
   always @(posedge bank_write_reg) bregs[bank_rd] <= bank_write_data;
   always @(posedge bank_read_reg) begin
      bd1 <= bregs[bank_rs];
      bd2 <= bregs[bank_rt];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_zero(input string t);
      chk({t, "_ctl"}, {11'd0, req_ready, rsp_valid, rsp_id, bank_rs, bank_rt, bank_rd, bank_write_reg, bank_read_reg}, 32'd0);
      chk({t, "_data"}, rsp_data_1 | rsp_data_2 | bank_write_data, 32'd0);
   endtask

   // One clock of the reference model: an accepted operation completes 4 cycles later, strobe at +2
   task automatic step();
      logic [1:0] er;
      logic win;
      #1;
      win = (valid == 2'b11) ? !last_g : valid[1];
      er = (rst_n && (age < 0 || age >= 4) && valid != 2'b00) ? (2'b01 << win) : 2'b00;
      chk("req_ready", {30'd0, req_ready}, {30'd0, er});
      chk("write_strobe", {31'd0, bank_write_reg}, {31'd0, age == 2 && o_w && o_rd != 5'd0});
      chk("read_strobe", {31'd0, bank_read_reg}, {31'd0, age == 2 && !o_w});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, age == 4});
      if (age == 4) chk("rsp_id", {31'd0, rsp_id}, {31'd0, o_id});
      chk("rsp_data_1", rsp_data_1, e_d1);
      chk("rsp_data_2", rsp_data_2, e_d2);
      if (age >= 1 && age <= 3) begin
         chk("bank_addr", {17'd0, bank_rs, bank_rt, bank_rd}, {17'd0, o_rs, o_rt, o_rd});
         chk("bank_wdata", bank_write_data, o_wd);
      end
      hs = er;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         age = -1; last_g = 1'b1; e_d1 = '0; e_d2 = '0;
      end else begin
         if (age >= 0) age++;
         if (age == 4 && !o_w) begin e_d1 = r_d1; e_d2 = r_d2; end
         if (hs != 2'b00) begin
            o_id = hs[1];
            o_w  = write[o_id];
            o_rs = o_id ? rs[9:5] : rs[4:0];
            o_rt = o_id ? rt[9:5] : rt[4:0];
            o_rd = o_id ? rd[9:5] : rd[4:0];
            o_wd = o_id ? wdata[63:32] : wdata[31:0];
            if (o_w && o_rd != 5'd0) mregs[o_rd] = o_wd;
            r_d1 = mregs[o_rs];
            r_d2 = mregs[o_rt];
            last_g = o_id;
            age = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic issue(input bit id, input bit w, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [31:0] wd, output int hc);
      int k = 0;
      valid[id] = 1'b1;
      write[id] = w;
      if (id) begin rs[9:5] = a; rt[9:5] = b; rd[9:5] = d; wdata[63:32] = wd; end
      else begin rs[4:0] = a; rt[4:0] = b; rd[4:0] = d; wdata[31:0] = wd; end
      do begin
         hc = cyc;
         step();
         k++;
      end while (!hs[id] && k < 12);
      chk("issue_handshake", {31'd0, hs[id]}, 32'd1);
      valid[id] = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      valid = 2'b11;
      #1 check_zero("reset");
      valid = 2'b00;
      rst_n = 1'b1;
      step();
      issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, h1);
      repeat (3) step();
      issue(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0, h1);
      repeat (4) step();
      valid = 2'b11; write = 2'b00;
      for (int n = 0; n < 16; n++) begin
         step();
         for (int i = 0; i < 2; i++) if (hs[i]) begin
            rs[i*5 +: 5] = 5'($urandom_range(0, 7));
            rt[i*5 +: 5] = 5'($urandom_range(0, 7));
         end
      end
      valid = 2'b00;
      repeat (4) step();
      issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678, h1);
      repeat (4) step();
      issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0, h1);
      repeat (4) step();
      issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'hA5A5C3C3, h1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1 check_zero("mid_reset");
      repeat (4) step();
      issue(1'b1, 1'b0, 5'd9, 5'd5, 5'd0, 32'h0, h1);
      repeat (4) step();
      issue(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, h1);
      issue(1'b0, 1'b0, 5'd2, 5'd3, 5'd0, 32'h0, h2);
      issue(1'b0, 1'b0, 5'd3, 5'd1, 5'd0, 32'h0, h3);
      chk("b2b_gap_1", h2 - h1, 32'd4);
      chk("b2b_gap_2", h3 - h2, 32'd4);
      repeat (4) step();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (hs[i] || !valid[i]) begin
               valid[i] = $urandom_range(0, 2) != 0;
               write[i] = 1'($urandom_range(0, 1));
               rs[i*5 +: 5] = 5'($urandom_range(0, 7));
               rt[i*5 +: 5] = 5'($urandom_range(0, 7));
               rd[i*5 +: 5] = 5'($urandom_range(0, 7));
               wdata[i*32 +: 32] = $urandom;
            end else if ($urandom_range(0, 15) == 0) valid[i] = 1'b0;
         end
         step();
      end
      valid = 2'b00;
      repeat (5) step();
      p_valid = 2'b11;
      for (int c = 0; c < 17; c++) begin
         #1;
         chk("cp_ready", {30'd0, p_ready}, (c % 4 == 0) ? 32'd1 : 32'd0);
         chk("cp_rsp_valid", {31'd0, p_rsp_valid}, (c % 4 == 0 && c > 0) ? 32'd1 : 32'd0);
         if (c % 4 == 0 && c > 0) chk("cp_rsp_id", {31'd0, p_rsp_id}, 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      p_valid = 2'b00;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
